// File: rtl/cw_sample_dump.sv
// cw_sample_dump: streams a window of the capture buffer out as bytes.
// A dump is a 4-byte header (A5 5A cnt_hi cnt_lo) followed by cnt samples,
// each sent as NBYTES bytes, most significant byte first. Read pointer wraps
// modulo DEPTH so a window may straddle the end of the circular buffer.
module cw_sample_dump #(
  parameter int DEPTH    = 2048,
  parameter int ADDR_W   = 11,
  parameter int SAMPLE_W = 49,
  parameter int NBYTES   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     count,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_last,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = ADDR_W + 1;
  // Byte index must cover both the 4 header bytes and NBYTES sample bytes.
  localparam int BI_W  = (NBYTES > 4) ? $clog2(NBYTES) : 2;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [BI_W-1:0]   BI_ZERO  = {BI_W{1'b0}};
  localparam logic [BI_W-1:0]   BI_ONE   = BI_W'(1);
  localparam logic [BI_W-1:0]   HDR_LAST = BI_W'(3);
  localparam logic [BI_W-1:0]   SMP_LAST = BI_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Header byte for a given position; cnt is the clamped count as 12 bits.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [11:0] c);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'hA5;
      2'd1:    b = 8'h5A;
      2'd2:    b = {4'h0, c[11:8]};
      2'd3:    b = c[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte idx of a sample, byte 0 being the most significant (zero padded).
  function automatic logic [7:0] sample_byte(input logic [SAMPLE_W-1:0] s,
                                             input logic [BI_W-1:0]     idx);
    logic [NBYTES*8-1:0] padded;
    logic [7:0]          b;
    padded = (NBYTES*8)'(s);
    b      = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      b = (idx == BI_W'(k)) ? padded[8*(NBYTES-1-k) +: 8] : b;
    end
    return b;
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_W-1:0]     ptr_r, ptr_s;
  logic [CNT_W-1:0]      rem_r, rem_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [SAMPLE_W-1:0]   hold_r, hold_s;
  logic [BI_W-1:0]       bidx_r, bidx_s;
  logic                  rd_en_r, rd_en_s;
  logic [ADDR_W-1:0]     rd_addr_r, rd_addr_s;
  logic [7:0]            tx_data_r, tx_data_s;
  logic                  tx_valid_r, tx_valid_s;
  logic                  tx_last_r, tx_last_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;

  logic                  xfer_s;
  logic [BI_W-1:0]       bidx_nx_s;
  logic [ADDR_W-1:0]     ptr_nx_s;
  logic [CNT_W-1:0]      count_clamp_s;
  logic [11:0]           hdr_cnt_s;

  assign xfer_s        = tx_valid_r & tx_ready;
  assign bidx_nx_s     = bidx_r + BI_ONE;
  assign ptr_nx_s      = (ptr_r == PTR_MAX) ? PTR_ZERO : (ptr_r + ADDR_W'(1));
  assign count_clamp_s = (count > DEPTH_C) ? DEPTH_C : count;
  assign hdr_cnt_s     = 12'(cnt_r);

  assign rd_en    = rd_en_r;
  assign rd_addr  = rd_addr_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign tx_last  = tx_last_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Next-state and next-output decode; outputs hold unless a byte moves.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    rem_s      = rem_r;
    cnt_s      = cnt_r;
    hold_s     = hold_r;
    bidx_s     = bidx_r;
    rd_en_s    = 1'b0;
    rd_addr_s  = rd_addr_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    tx_last_s  = tx_last_r;
    busy_s     = busy_r;
    done_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          cnt_s      = count_clamp_s;
          rem_s      = count_clamp_s;
          ptr_s      = start_addr;
          bidx_s     = BI_ZERO;
          tx_data_s  = 8'hA5;
          tx_valid_s = 1'b1;
          tx_last_s  = 1'b0;
          busy_s     = 1'b1;
          state_s    = HDR;
        end else begin
          state_s    = IDLE;
        end
      end

      HDR: begin
        if (xfer_s) begin
          if (bidx_r == HDR_LAST) begin
            tx_valid_s = 1'b0;
            tx_last_s  = 1'b0;
            tx_data_s  = 8'h00;
            if (cnt_r != CNT_ZERO) begin
              rd_en_s   = 1'b1;
              rd_addr_s = ptr_r;
              state_s   = FETCH;
            end else begin
              done_s    = 1'b1;
              busy_s    = 1'b0;
              state_s   = FIN;
            end
          end else begin
            bidx_s    = bidx_nx_s;
            tx_data_s = hdr_byte(bidx_nx_s[1:0], hdr_cnt_s);
            tx_last_s = (bidx_nx_s == HDR_LAST) && (cnt_r == CNT_ZERO);
          end
        end else begin
          state_s = HDR;
        end
      end

      FETCH: begin
        // rd_en was raised on entry; the read data arrives during WAIT.
        state_s = WAIT;
      end

      WAIT: begin
        hold_s     = rd_data;
        ptr_s      = ptr_nx_s;
        rem_s      = rem_r - CNT_ONE;
        bidx_s     = BI_ZERO;
        tx_data_s  = sample_byte(rd_data, BI_ZERO);
        tx_valid_s = 1'b1;
        tx_last_s  = (NBYTES == 1) && (rem_r == CNT_ONE);
        state_s    = SEND;
      end

      SEND: begin
        if (xfer_s) begin
          if (bidx_r == SMP_LAST) begin
            tx_valid_s = 1'b0;
            tx_last_s  = 1'b0;
            tx_data_s  = 8'h00;
            if (rem_r != CNT_ZERO) begin
              rd_en_s   = 1'b1;
              rd_addr_s = ptr_r;
              state_s   = FETCH;
            end else begin
              done_s    = 1'b1;
              busy_s    = 1'b0;
              state_s   = FIN;
            end
          end else begin
            bidx_s    = bidx_nx_s;
            tx_data_s = sample_byte(hold_r, bidx_nx_s);
            tx_last_s = (bidx_nx_s == SMP_LAST) && (rem_r == CNT_ZERO);
          end
        end else begin
          state_s = SEND;
        end
      end

      FIN: begin
        state_s = IDLE;
      end

      default: begin
        tx_valid_s = 1'b0;
        tx_last_s  = 1'b0;
        busy_s     = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_ZERO;
      rem_r      <= CNT_ZERO;
      cnt_r      <= CNT_ZERO;
      hold_r     <= {SAMPLE_W{1'b0}};
      bidx_r     <= BI_ZERO;
      rd_en_r    <= 1'b0;
      rd_addr_r  <= PTR_ZERO;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      tx_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      rem_r      <= rem_s;
      cnt_r      <= cnt_s;
      hold_r     <= hold_s;
      bidx_r     <= bidx_s;
      rd_en_r    <= rd_en_s;
      rd_addr_r  <= rd_addr_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      tx_last_r  <= tx_last_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

endmodule

// File: tb/tb_cw_sample_dump.sv
// Directed bench for cw_sample_dump: table of dump requests with hand-computed
// header/byte/read counts, plus hand sequences for reset abort and restart.
module tb_cw_sample_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] count;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [48:0] rd_data = 49'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [48:0] mem [0:2047];
  logic [8:0]  byte_q [$];
  logic [10:0] addr_q [$];
  int          done_cnt  = 0;
  int          proto_err = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  data_prev  = 8'h00;
  logic        last_prev  = 1'b0;
  logic        rd_prev    = 1'b0;
  bit          rnd_mode   = 1'b0;

  typedef struct {
    int         addr;
    int         cnt;
    bit         rnd;
    int         exp_bytes;
    int         exp_reads;
    logic [7:0] h2;
    logic [7:0] h3;
  } vec_t;

  vec_t vt [7];

  cw_sample_dump dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Buffer model: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Observe transfers, reads, done pulses and handshake rule violations.
  always @(posedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) byte_q.push_back({tx_last, tx_data});
      if (rd_en) addr_q.push_back(rd_addr);
      if (done) done_cnt <= done_cnt + 1;
      if ((done && busy) || (rd_en && rd_prev) ||
          (stall_prev && (!tx_valid || tx_data != data_prev || tx_last != last_prev)))
        proto_err <= proto_err + 1;
    end
    stall_prev <= !rst && tx_valid && !tx_ready;
    data_prev  <= tx_data;
    last_prev  <= tx_last;
    rd_prev    <= rd_en;
  end

  // Downstream ready: constant 1 or random toggling.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " rd_en"},    rd_en, 0);
    chk({nm, " rd_addr"},  rd_addr, 0);
    chk({nm, " tx_valid"}, tx_valid, 0);
    chk({nm, " tx_data"},  tx_data, 0);
    chk({nm, " tx_last"},  tx_last, 0);
    chk({nm, " busy"},     busy, 0);
    chk({nm, " done"},     done, 0);
  endtask

  task automatic start_dump(input string nm, input int a, input int c);
    @(negedge clk);
    start_addr = 11'(a);
    count      = 12'(c);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    chk({nm, " first tx_valid"}, tx_valid, 1);
    chk({nm, " first busy"},     busy, 1);
    chk({nm, " first byte"},     tx_data, 8'hA5);
  endtask

  task automatic wait_done(input string nm, input int limit);
    bit seen = 1'b0;
    int db   = done_cnt;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        chk({nm, " busy during done"}, busy, 0);
      end
    end
    chk({nm, " done seen"}, seen, 1);
    repeat (4) @(negedge clk);
    chk({nm, " done pulses"}, done_cnt - db, 1);
    chk({nm, " idle after"}, {busy, tx_valid, done}, 0);
  endtask

  task automatic check_dump(input string nm, input int addr, input int exp_bytes,
                            input int exp_reads, input logic [7:0] h2, input logic [7:0] h3,
                            input int bb, input int ab, input int pb);
    logic [8:0]  exp_q [$];
    logic [48:0] s;
    int          nact, nbad, first;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, h2});
    exp_q.push_back({(exp_reads == 0), h3});
    for (int i = 0; i < exp_reads; i++) begin
      s = mem[(addr + i) % 2048];
      exp_q.push_back({1'b0, 7'b0, s[48]});
      for (int j = 5; j >= 0; j--)
        exp_q.push_back({((i == exp_reads - 1) && (j == 0)), s[j*8 +: 8]});
    end
    nact = byte_q.size() - bb;
    chk({nm, " byte count"}, nact, exp_bytes);
    chk({nm, " hdr2"}, (nact >= 4) ? longint'(byte_q[bb+2][7:0]) : -1, h2);
    chk({nm, " hdr3"}, (nact >= 4) ? longint'(byte_q[bb+3][7:0]) : -1, h3);
    nbad  = 0;
    first = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= nact || byte_q[bb+k] != exp_q[k]) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    chk($sformatf("%s stream mismatches first@%0d", nm, first), nbad, 0);
    chk({nm, " rd_en pulses"}, addr_q.size() - ab, exp_reads);
    nbad = 0;
    for (int i = 0; i < exp_reads; i++) begin
      if (ab + i >= addr_q.size() || addr_q[ab+i] != 11'((addr + i) % 2048)) nbad++;
    end
    chk({nm, " rd_addr sequence errors"}, nbad, 0);
    chk({nm, " protocol errors"}, proto_err - pb, 0);
  endtask

  initial begin
    logic [7:0] exp36 [18];
    int bb, ab, pb, nbad, lastpos;

    rst = 1'b1; start = 1'b0; start_addr = 11'd0; count = 12'd0;
    for (int i = 0; i < 2048; i++)
      mem[i] = 49'(i) * 49'h0_0000_9E37_79B1 + 49'h1_5A5A_0000_1234;
    mem[5] = 49'h1_2345_6789_ABCD;
    mem[6] = 49'h0;

    exp36 = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
              8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    vt[0] = '{5,    2,    1'b0, 18,    2,    8'h00, 8'h02};
    vt[1] = '{2046, 3,    1'b0, 25,    3,    8'h00, 8'h03};
    vt[2] = '{0,    0,    1'b0, 4,     0,    8'h00, 8'h00};
    vt[3] = '{100,  4000, 1'b0, 14340, 2048, 8'h08, 8'h00};
    vt[4] = '{7,    5,    1'b1, 39,    5,    8'h00, 8'h05};
    vt[5] = '{2040, 10,   1'b1, 74,    10,   8'h00, 8'h0A};
    vt[6] = '{1,    2048, 1'b0, 14340, 2048, 8'h08, 8'h00};

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      rnd_mode = vt[t].rnd;
      bb = byte_q.size(); ab = addr_q.size(); pb = proto_err;
      start_dump($sformatf("vec%0d", t), vt[t].addr, vt[t].cnt);
      wait_done($sformatf("vec%0d", t), vt[t].exp_bytes * 6 + 100);
      check_dump($sformatf("vec%0d", t), vt[t].addr, vt[t].exp_bytes, vt[t].exp_reads,
                 vt[t].h2, vt[t].h3, bb, ab, pb);
    end

    // Literal byte stream for the addr 5 / count 2 example.
    rnd_mode = 1'b0;
    bb = byte_q.size();
    start_dump("lit", 5, 2);
    wait_done("lit", 200);
    nbad = 0; lastpos = -1;
    for (int k = 0; k < 18; k++) begin
      if (bb + k >= byte_q.size() || byte_q[bb+k][7:0] != exp36[k]) nbad++;
      else if (byte_q[bb+k][8]) lastpos = k;
    end
    chk("lit bytes wrong", nbad, 0);
    chk("lit tx_last position", lastpos, 17);

    // A start while busy must not restart or redirect the dump.
    rnd_mode = 1'b1;
    bb = byte_q.size(); ab = addr_q.size(); pb = proto_err;
    start_dump("busy_start", 20, 2);
    repeat (6) @(negedge clk);
    start_addr = 11'd0; count = 12'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 400);
    check_dump("busy_start", 20, 18, 2, 8'h00, 8'h02, bb, ab, pb);

    // Reset in the middle of a sample, start held high during reset.
    rnd_mode = 1'b0;
    bb = byte_q.size();
    start_dump("abort", 300, 3);
    for (int i = 0; i < 200 && byte_q.size() < bb + 7; i++) @(negedge clk);
    chk("abort reached SEND", byte_q.size() >= bb + 7, 1);
    rst = 1'b1; start = 1'b1; start_addr = 11'd0; count = 12'd5;
    @(negedge clk);
    chk_reset_outs("abort reset");
    start = 1'b0;
    @(negedge clk);
    chk_reset_outs("abort held");
    rst = 1'b0;
    bb = byte_q.size(); ab = addr_q.size(); pb = proto_err;
    rnd_mode = 1'b1;
    start_dump("restart", 2047, 2);
    wait_done("restart", 400);
    check_dump("restart", 2047, 18, 2, 8'h00, 8'h02, bb, ab, pb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cw_sample_dump.md
CW_SAMPLE_DUMP -- requirements
Module: cw_sample_dump

Interface
REQ-001 Parameter DEPTH, default 2048, sample buffer depth in entries.
REQ-002 Parameter ADDR_W, default 11, buffer address width (log2 DEPTH).
REQ-003 Parameter SAMPLE_W, default 49, captured sample width (probe buses 24+12+12+1 concatenated).
REQ-004 Parameter NBYTES, default 7, bytes per sample on output (ceil(SAMPLE_W/8)).
REQ-005 Ports below; one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle dump request.
REQ-009 start_addr  in  ADDR_W  address of oldest sample to dump.
REQ-010 count  in  ADDR_W+1  number of samples to dump.
REQ-011 rd_en  out  1  sample buffer read strobe.
REQ-012 rd_addr  out  ADDR_W  sample buffer read address.
REQ-013 rd_data  in  SAMPLE_W  buffer read data, valid exactly 1 cycle after rd_en.
REQ-014 tx_data  out  8  output byte.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  downstream accepts byte.
REQ-017 tx_last  out  1  final byte of dump.
REQ-018 busy  out  1  dump in progress.
REQ-019 done  out  1  one-cycle pulse when dump completes.

Function
REQ-020 The block SHALL implement states IDLE, HDR, FETCH, WAIT, SEND, FIN.
REQ-021 In IDLE, start SHALL latch start_addr, latch count clamped to DEPTH, and enter HDR next cycle; start while busy=1 SHALL be ignored.
REQ-022 HDR SHALL emit 4 bytes in order: 0xA5, 0x5A, {4'h0, cnt[11:8]}, cnt[7:0], where cnt is the clamped count zero-extended to 12 bits.
REQ-023 tx_valid SHALL assert the cycle after start is sampled; a byte is transferred only on tx_valid&&tx_ready.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data, tx_last and tx_valid SHALL hold stable.
REQ-025 After the last header byte transfers: cnt>0 -> FETCH; cnt=0 -> FIN, with tx_last=1 on header byte 3.
REQ-026 FETCH SHALL assert rd_en for one cycle with rd_addr = current pointer, then enter WAIT.
REQ-027 WAIT SHALL register rd_data into a SAMPLE_W-bit holding register, increment the pointer modulo DEPTH (2047 wraps to 0), decrement remaining, and enter SEND.
REQ-028 SEND SHALL emit NBYTES bytes MSB first: byte0 = {7'b0, sample[48]}, byte1 = sample[47:40] ... byte6 = sample[7:0]; unused high bits of byte0 SHALL be 0.
REQ-029 After byte NBYTES-1 transfers: remaining>0 -> FETCH; else -> FIN.
REQ-030 tx_last SHALL be 1 only on byte NBYTES-1 of the final sample (or header byte 3 when cnt=0).
REQ-031 FIN SHALL pulse done for exactly one cycle, deassert busy, and return to IDLE.
REQ-032 busy SHALL be 1 from the cycle after start is accepted through the cycle before done; rd_en SHALL never assert outside FETCH.
REQ-033 count > DEPTH SHALL be clamped to DEPTH; exactly cnt samples SHALL be read, no address read twice for cnt=DEPTH.

Reset
REQ-034 With rst=1 at a clock edge, the block SHALL enter IDLE and drive rd_en=0, rd_addr=0, tx_valid=0, tx_data=0, tx_last=0, busy=0, done=0.
REQ-035 rst SHALL take priority over start and abort any dump mid-transfer with no further bytes emitted.

Verification
REQ-036 start, start_addr=5, count=2, tx_ready=1, buffer[5]=49'h1_2345_6789_ABCD, buffer[6]=0 -> bytes A5 5A 00 02 01 23 45 67 89 AB CD 00 00 00 00 00 00 00, tx_last on byte 18, done one pulse.
REQ-037 start_addr=2046, count=3 -> rd_addr sequence 2046, 2047, 0.
REQ-038 count=0 -> bytes A5 5A 00 00, tx_last on 4th byte, rd_en never asserted, done pulses.
REQ-039 count=4000 -> header 08 00 after A5 5A, exactly 2048 rd_en pulses, 4+2048*7 bytes total.
REQ-040 Random tx_ready toggling -> byte stream identical to tx_ready=1 case; tx_data stable whenever tx_valid&&!tx_ready.
REQ-041 rst asserted mid-SEND, then second start during reset release cycle+1 -> all outputs at reset values, new dump starts cleanly with header 0xA5; start during busy ignored.
